// File: rtl/tl_pkg.sv
// Shared phase encoding and default timing for the intersection controller.
package tl_pkg;

  localparam int unsigned PHASE_W      = 2;
  localparam int unsigned LFSR_W       = 7;
  localparam int unsigned GREEN_T_DEF  = 20;
  localparam int unsigned YELLOW_T_DEF = 3;
  localparam int unsigned ALLRED_T_DEF = 1;
  localparam int unsigned GAP_T_DEF    = 4;
  localparam int unsigned JITTER_W_DEF = 2;
  localparam logic [LFSR_W-1:0] SEED_DEF = 7'h5A;

  typedef enum logic [PHASE_W-1:0] {
    TL_IDLE   = 2'd0,
    TL_GREEN  = 2'd1,
    TL_YELLOW = 2'd2,
    TL_ALLRED = 2'd3
  } tl_phase_e;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Sensor-in / lamp-out bundle between lane sensors, controller and lamp drivers.
interface tl_if #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned LANE_W  = $clog2(N_LANES)
) ();

  logic [N_LANES-1:0] car_i;
  logic [N_LANES-1:0] green_o;
  logic [N_LANES-1:0] yellow_o;
  logic [LANE_W-1:0]  active_lane_o;
  logic [1:0]         phase_o;
  logic [CNT_W-1:0]   count_down_o;

  modport master (
    output car_i,
    input  green_o, yellow_o, active_lane_o, phase_o, count_down_o
  );

  modport slave (
    input  car_i,
    output green_o, yellow_o, active_lane_o, phase_o, count_down_o
  );

endinterface

// File: rtl/tl_lfsr.sv
// Free-running 7-bit Fibonacci LFSR (x^7+x^6+1) supplying green-time jitter.
module tl_lfsr
  import tl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[5:0], q[6] ^ q[5]};
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin intersection controller: GREEN -> YELLOW -> ALL_RED per grant, with gap-out.
// Optional green jitter from an LFSR is enabled by defining TL_LFSR_JITTER_EN.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned N_LANES  = 4,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned GREEN_T  = GREEN_T_DEF,
  parameter int unsigned YELLOW_T = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T = ALLRED_T_DEF,
  parameter int unsigned GAP_T    = GAP_T_DEF
`ifdef TL_LFSR_JITTER_EN
  ,
  parameter int unsigned       JITTER_W = JITTER_W_DEF,
  parameter logic [LFSR_W-1:0] SEED     = SEED_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  tl_if.slave  bus
);

  localparam int unsigned LANE_W = $clog2(N_LANES);

  tl_phase_e          phase_q, phase_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [LANE_W-1:0]  lane_q, lane_n;
  logic [N_LANES-1:0] green_q, green_n;
  logic [N_LANES-1:0] yellow_q, yellow_n;
  logic [CNT_W-1:0]   green_load;
  logic [LANE_W-1:0]  pick;
  logic [N_LANES-1:0] cur_mask;
  logic               any_car;
  logic               gap_out;

  // First requesting lane after `last`, wrapping; `last` itself is checked last.
  function automatic logic [LANE_W-1:0] rr_pick(input logic [N_LANES-1:0] req,
                                                input logic [LANE_W-1:0]  last);
    int idx;
    rr_pick = last;
    for (int i = int'(N_LANES); i >= 1; i--) begin
      idx = (int'(last) + i) % int'(N_LANES);
      if (req[idx]) rr_pick = LANE_W'(idx);
    end
  endfunction

  function automatic logic [N_LANES-1:0] lane_mask(input logic [LANE_W-1:0] lane);
    lane_mask = N_LANES'(1) << lane;
  endfunction

`ifdef TL_LFSR_JITTER_EN
  logic [LFSR_W-1:0] lfsr_q;

  tl_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign green_load = CNT_W'(GREEN_T - 1) + CNT_W'(lfsr_q[JITTER_W-1:0]);
`else
  assign green_load = CNT_W'(GREEN_T - 1);
`endif

  assign any_car  = |bus.car_i;
  assign pick     = rr_pick(bus.car_i, lane_q);
  assign cur_mask = lane_mask(lane_q);
  assign gap_out  = ((bus.car_i & cur_mask) == '0) && (cnt_q > CNT_W'(GAP_T))
                    && ((bus.car_i & ~cur_mask) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= TL_IDLE;
      cnt_q    <= '0;
      lane_q   <= LANE_W'(N_LANES - 1);
      green_q  <= '0;
      yellow_q <= '0;
    end else begin
      phase_q  <= phase_n;
      cnt_q    <= cnt_n;
      lane_q   <= lane_n;
      green_q  <= green_n;
      yellow_q <= yellow_n;
    end
  end

  // Next state, counter and lamp values; lamps follow the state they belong to.
  always_comb begin
    phase_n  = phase_q;
    cnt_n    = cnt_q;
    lane_n   = lane_q;
    green_n  = '0;
    yellow_n = '0;
    unique case (phase_q)
      TL_IDLE: begin
        if (any_car) begin
          phase_n = TL_GREEN;
          lane_n  = pick;
          cnt_n   = green_load;
          green_n = lane_mask(pick);
        end
      end
      TL_GREEN: begin
        if (cnt_q == '0) begin
          phase_n  = TL_YELLOW;
          cnt_n    = CNT_W'(YELLOW_T - 1);
          yellow_n = cur_mask;
        end else begin
          cnt_n   = gap_out ? CNT_W'(GAP_T) : cnt_q - CNT_W'(1);
          green_n = cur_mask;
        end
      end
      TL_YELLOW: begin
        if (cnt_q == '0) begin
          phase_n = TL_ALLRED;
          cnt_n   = CNT_W'(ALLRED_T - 1);
        end else begin
          cnt_n    = cnt_q - CNT_W'(1);
          yellow_n = cur_mask;
        end
      end
      TL_ALLRED: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else if (any_car) begin
          phase_n = TL_GREEN;
          lane_n  = pick;
          cnt_n   = green_load;
          green_n = lane_mask(pick);
        end else begin
          phase_n = TL_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        phase_n = TL_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.green_o       = green_q;
  assign bus.yellow_o      = yellow_q;
  assign bus.active_lane_o = lane_q;
  assign bus.phase_o       = phase_q;
  assign bus.count_down_o  = cnt_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed-vector bench for traffic_light_ctrl in its default (no-jitter) build.
module tb_traffic_light_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  tl_if #(.N_LANES(4), .CNT_W(5)) bus ();

  traffic_light_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] car;
    logic [1:0] ph;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] ln;
    logic [4:0] c;
  } vec_t;

  vec_t vecs [40];

  task automatic check(input string name, input logic [1:0] ph, input logic [3:0] g,
                       input logic [3:0] y, input logic [1:0] ln, input logic [4:0] c);
    tests++;
    if (bus.phase_o !== ph || bus.green_o !== g || bus.yellow_o !== y ||
        bus.active_lane_o !== ln || bus.count_down_o !== c) begin
      fails++;
      $display("FAIL %s: got ph=%0d g=%b y=%b lane=%0d cnt=%0d, want ph=%0d g=%b y=%b lane=%0d cnt=%0d",
               name, bus.phase_o, bus.green_o, bus.yellow_o, bus.active_lane_o, bus.count_down_o,
               ph, g, y, ln, c);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.car_i = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    int bad_lamp;
    int budget;
    logic [1:0] prev_ph;
    logic [1:0] exp_grant [4];

    tests = 0;
    fails = 0;

    // Default timing: green 20, yellow 3, all-red 1, gap-out remainder 4.
    for (int v = 0; v < 40; v++) begin
      vecs[v].car = (v < 29) ? 4'b0001 : 4'b0100;
      vecs[v].ln  = (v < 38) ? 2'd0 : 2'd2;
      vecs[v].g   = 4'b0000;
      vecs[v].y   = 4'b0000;
      vecs[v].c   = 5'd0;
      if (v <= 19) begin
        vecs[v].ph = 2'd1; vecs[v].g = 4'b0001; vecs[v].c = 5'(19 - v);
      end else if (v <= 22) begin
        vecs[v].ph = 2'd2; vecs[v].y = 4'b0001; vecs[v].c = 5'(22 - v);
      end else if (v == 23) begin
        vecs[v].ph = 2'd3;
      end else if (v <= 28) begin
        vecs[v].ph = 2'd1; vecs[v].g = 4'b0001; vecs[v].c = 5'(43 - v);
      end else if (v <= 33) begin
        vecs[v].ph = 2'd1; vecs[v].g = 4'b0001; vecs[v].c = 5'(33 - v);
      end else if (v <= 36) begin
        vecs[v].ph = 2'd2; vecs[v].y = 4'b0001; vecs[v].c = 5'(36 - v);
      end else if (v == 37) begin
        vecs[v].ph = 2'd3;
      end else begin
        vecs[v].ph = 2'd1; vecs[v].g = 4'b0100; vecs[v].c = 5'(57 - v);
      end
    end

    do_reset();
    #1 check("reset_state", 2'd0, 4'b0000, 4'b0000, 2'd3, 5'd0);

    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle_%0d", i), 2'd0, 4'b0000, 4'b0000, 2'd3, 5'd0);
    end

    // Full lane-0 cycle, regrant of lane 0, then gap-out at count 15 toward lane 2.
    for (int v = 0; v < 40; v++) begin
      bus.car_i = vecs[v].car;
      @(posedge clk); #1;
      check($sformatf("vec_%0d", v), vecs[v].ph, vecs[v].g, vecs[v].y, vecs[v].ln, vecs[v].c);
    end

    // Round-robin between lanes 1 and 3 only.
    do_reset();
    bus.car_i    = 4'b1010;
    exp_grant[0] = 2'd1; exp_grant[1] = 2'd3; exp_grant[2] = 2'd1; exp_grant[3] = 2'd3;
    grants   = 0;
    bad_lamp = 0;
    budget   = 0;
    prev_ph  = 2'd0;
    while (grants < 4 && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      if (((bus.green_o | bus.yellow_o) & 4'b0101) != 4'b0000) bad_lamp++;
      if (!$onehot0(bus.green_o | bus.yellow_o)) bad_lamp++;
      if (bus.phase_o == 2'd1 && prev_ph != 2'd1) begin
        tests++;
        if (bus.active_lane_o !== exp_grant[grants]) begin
          fails++;
          $display("FAIL rr_grant_%0d: got lane %0d, want lane %0d",
                   grants, bus.active_lane_o, exp_grant[grants]);
        end
        grants++;
      end
      prev_ph = bus.phase_o;
    end
    tests++;
    if (grants != 4) begin
      fails++;
      $display("FAIL rr_timeout: got %0d grants, want 4", grants);
    end
    tests++;
    if (bad_lamp != 0) begin
      fails++;
      $display("FAIL rr_lamps: got %0d bad lamp cycles, want 0", bad_lamp);
    end

    // Asynchronous reset in the middle of GREEN.
    do_reset();
    bus.car_i = 4'b0001;
    repeat (4) @(posedge clk);
    #1 check("pre_rst_green", 2'd1, 4'b0001, 4'b0000, 2'd0, 5'd16);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 2'd0, 4'b0000, 4'b0000, 2'd3, 5'd0);
    bus.car_i = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 2'd0, 4'b0000, 4'b0000, 2'd3, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised intersection controller that grants green to one of N_LANES approaches at a time. Grants rotate round-robin among lanes with waiting cars, and each grant runs a GREEN → YELLOW → ALL_RED sequence with a visible countdown. Successor to the fixed 4-lane, fixed-20 countdown light, adding gap-out and optional pseudo-random green jitter. Sits between lane car sensors and lamp drivers/display.

Parameters:
N_LANES, 4, number of approaches (2..16)
LANE_W, $clog2(N_LANES), lane index width (derived)
CNT_W, 5, countdown width; must hold GREEN_T-1 + 2^JITTER_W-1
GREEN_T, 20, nominal green cycles
YELLOW_T, 3, yellow cycles
ALLRED_T, 1, all-red clearance cycles
GAP_T, 4, remaining green after gap-out
JITTER_W, 2, jitter bits (used only with TL_LFSR_JITTER_EN)
SEED, 7'h5A, LFSR reset seed (non-zero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
car_i  in  N_LANES  car-waiting sensor per lane, synchronous to clk
green_o  out  N_LANES  one-hot green lamp, or 0
yellow_o  out  N_LANES  one-hot yellow lamp, or 0
active_lane_o  out  LANE_W  lane currently/last granted
phase_o  out  2  0=IDLE 1=GREEN 2=YELLOW 3=ALL_RED
count_down_o  out  CNT_W  cycles remaining in phase minus 1; 0 in IDLE

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; green_o=0, yellow_o=0, count_down_o=0, phase_o=0.
  - active_lane_o=N_LANES-1, so the first grant favours lane 0.
  - LFSR=SEED.
- Grant selection: the first lane with car_i=1 searching active_lane+1, +2, … with wrap, current lane checked last.
- Phase entry: counter loads T-1. It decrements each cycle. The transition happens on the cycle it reads 0, so a phase lasts exactly T cycles.
- IDLE:
  - If any car_i is set, next cycle enter GREEN for the selected lane, latch active_lane_o, load GREEN_T-1.
  - Otherwise stay; all lamps off (all red).
- GREEN:
  - green_o[active]=1.
  - Gap-out: if car_i[active]=0, counter>GAP_T, and another lane has car_i=1, counter loads GAP_T next cycle instead of decrementing.
  - Counter 0 → YELLOW, load YELLOW_T-1.
- YELLOW: yellow_o[active]=1; counter 0 → ALL_RED, load ALLRED_T-1.
- ALL_RED: lamps off; counter 0 → if any car waiting, GREEN for the selected lane (same lane allowed if it is the only one waiting); else IDLE.
- Outputs are registered; lamp and phase change on the same edge as the state.
- A sensor change mid-phase never shortens YELLOW or ALL_RED.
- Invariant: never more than one lamp bit set across green_o|yellow_o.
- Reset mid-phase: lamps off immediately (asynchronously).

Optional Feature:
- Macro TL_LFSR_JITTER_EN.
- Defined:
  - 7-bit LFSR, polynomial x^7+x^6+1, shifts every cycle: q <= {q[5:0], q[6]^q[5]}.
  - On GREEN entry, load GREEN_T-1 + q[JITTER_W-1:0].
- Undefined: no LFSR logic; GREEN load is exactly GREEN_T-1.

Decomposition:
- Package tl_pkg: phase enum (TL_IDLE, TL_GREEN, TL_YELLOW, TL_ALLRED), phase width constant 2, default timing constants.
- One sub-module tl_lfsr (clk, rst_n, seed param, 7-bit q), instantiated only under TL_LFSR_JITTER_EN.
- Round-robin select stays as a function in the main module.

Test Plan:
- Reset, car_i=0 for 50 cycles → phase_o=0, lamps 0, count_down_o=0 throughout.
- car_i=4'b0001 held → green_o=0001 for 20 cycles (count 19..0), yellow 3 cycles, all-red 1 cycle, green lane 0 again.
- car_i=4'b1010 held → grant order lane 1, lane 3, lane 1, …; never lane 0 or 2.
- Lane 0 green at count 15, car_i drops to 4'b0100 → next cycle count_down_o=4, yellow after 5 more cycles, then lane 2 green.
- Assert rst_n=0 mid-GREEN → green_o=0 before next clk edge; after release, IDLE with active_lane_o=3.
- With TL_LFSR_JITTER_EN, seed 7'h5A → green lengths match the reference LFSR model, each within 20..23 cycles.
